// File: rtl/ps2_defs.sv
// ============================================================================
// Module   : ps2_defs
// Purpose  : Shared scan-code constants and frame FSM encoding for the PS/2 decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ps2_defs;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // PS/2 uses odd parity: data plus parity must hold an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// ============================================================================
// Module   : ps2_frame_rx
// Purpose  : Synchronises and filters the PS/2 lines, receives 11-bit frames and
//            aborts stalled frames. Parity checking enabled by PS2_PARITY_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_frame_rx
  import ps2_defs::*;
#(
  parameter int WATCHDOG_CYCLES = 50000,
  parameter int FILTER_LEN      = 4
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  logic [1:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       dat_sync_q, dat_sync_d;
  logic             clk_filt_q, clk_filt_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  rx_state_e        state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             fall;
  logic             dat_bit;
`ifdef PS2_PARITY_CHECK_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    clk_filt_d = clk_filt_q;
    flt_cnt_d  = '0;
    // The filtered level only moves after FILTER_LEN samples disagree with it in a row.
    if (clk_sync_q[1] != clk_filt_q) begin
      if (flt_cnt_q == FLT_LAST) begin
        clk_filt_d = clk_sync_q[1];
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  assign fall    = clk_filt_q & ~clk_filt_d;
  assign dat_bit = dat_sync_q[1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wd_d      = '0;
    rx_valid  = 1'b0;
    rx_err    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (fall && !dat_bit) begin
          state_d   = ST_DATA;
          bit_cnt_d = 4'd0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d   = {dat_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d   = dat_bit;
`endif
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (!dat_bit) begin
            rx_err = 1'b1;
          end else begin
`ifdef PS2_PARITY_CHECK_EN
            rx_valid = parity_ok(shift_q, par_q);
            rx_err   = ~parity_ok(shift_q, par_q);
`else
            rx_valid = 1'b1;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Stall detection leaves the prefix state in the decoder untouched.
    if (state_q != ST_IDLE && !fall) begin
      if (wd_q == WD_LAST) begin
        state_d = ST_IDLE;
        rx_err  = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      clk_filt_q <= 1'b0;
      flt_cnt_q  <= '0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      wd_q       <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_filt_q <= clk_filt_d;
      flt_cnt_q  <= flt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      wd_q       <= wd_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  assign rx_byte = shift_q;

endmodule

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : PS/2 keyboard decoder: E0/F0 prefix handling over ps2_frame_rx.
//            Optional parity checking via PS2_PARITY_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_key_decoder
  import ps2_defs::*;
#(
  parameter int WATCHDOG_CYCLES = 50000,
  parameter int FILTER_LEN      = 4
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_out,
  output logic       ps2_key_pressed,
  output logic       ps2_key_released,
  output logic       ps2_extended,
  output logic       ps2_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  logic [7:0] out_q, out_d;
  logic       extended_q, extended_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       pressed_q, pressed_d;
  logic       released_q, released_d;
  logic       err_q, err_d;

  ps2_frame_rx #(
    .WATCHDOG_CYCLES(WATCHDOG_CYCLES),
    .FILTER_LEN     (FILTER_LEN)
  ) u_rx (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  always_comb begin
    out_d      = out_q;
    extended_d = extended_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    err_d      = rx_err;

    if (rx_valid) begin
      if (rx_byte == SC_E0) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_F0) begin
        brk_d = 1'b1;
      end else begin
        // A break keeps the last make code visible so the host can match it.
        if (brk_q) begin
          released_d = 1'b1;
        end else begin
          out_d      = rx_byte;
          extended_d = ext_q;
          pressed_d  = 1'b1;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      out_q      <= 8'h00;
      extended_q <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      extended_q <= extended_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      err_q      <= err_d;
    end
  end

  assign ps2_out          = out_q;
  assign ps2_extended     = extended_q;
  assign ps2_key_pressed  = pressed_q;
  assign ps2_key_released = released_q;
  assign ps2_err          = err_q;

endmodule

`default_nettype wire
